// File: rtl/moment_accum.sv
// moment_accum: first and second moment (mean, mean square) of a vector
// of 2^N_LOG2 signed 16-bit samples.
//
// Configuration macro: MOMENT_ACCUM_ROUND_EN
//   undefined -> o_Ex / o_Ex2 are truncated (floor) divisions by 2^N_LOG2
//   defined   -> round-half-up, using one guard bit so the bias add cannot overflow
//
// Handshake: a sample is taken on a rising edge where i_valid && o_ready.
// o_ready drops only in the single DONE cycle, so the source holds i_valid
// (and i_x) and the sample is taken on the following edge.
module moment_accum #(
    parameter int N_LOG2 = 6
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic               i_valid,
    input  logic signed [15:0] i_x,
    input  logic               i_clear,
    output logic               o_ready,
    output logic               o_valid,
    output logic signed [21:0] o_Ex,
    output logic        [31:0] o_Ex2,
    output logic        [6:0]  o_count,
    output logic        [1:0]  o_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [6:0] TARGET = 7'(1 << N_LOG2);

    state_t             state_q, state_d;
    logic signed [21:0] sum_x_q, sum_x_d;
    logic        [36:0] sum_x2_q, sum_x2_d;
    logic        [6:0]  count_q, count_d;
    logic signed [21:0] ex_q, ex_d;
    logic        [31:0] ex2_q, ex2_d;

    logic               accept;
    logic signed [31:0] x_sq;

`ifdef MOMENT_ACCUM_ROUND_EN
    localparam logic signed [22:0] HALF_X  = 23'(1 << (N_LOG2 - 1));
    localparam logic        [37:0] HALF_X2 = 38'(1 << (N_LOG2 - 1));

    function automatic logic signed [21:0] mean_x(input logic signed [21:0] s);
        logic signed [22:0] g;
        g = {s[21], s} + HALF_X;
        return 22'(g >>> N_LOG2);
    endfunction

    function automatic logic [31:0] mean_x2(input logic [36:0] s);
        logic [37:0] g;
        g = {1'b0, s} + HALF_X2;
        return 32'(g >> N_LOG2);
    endfunction
`else
    function automatic logic signed [21:0] mean_x(input logic signed [21:0] s);
        return s >>> N_LOG2;
    endfunction

    function automatic logic [31:0] mean_x2(input logic [36:0] s);
        return 32'(s >> N_LOG2);
    endfunction
`endif

    // Handshake and square of the incoming sample (always non-negative).
    always_comb begin
        accept = i_valid && (state_q != DONE);
        x_sq   = i_x * i_x;
    end

    // Next-state, accumulator and result-register logic.
    always_comb begin
        state_d  = state_q;
        sum_x_d  = sum_x_q;
        sum_x2_d = sum_x2_q;
        count_d  = count_q;
        ex_d     = ex_q;
        ex2_d    = ex2_q;
        unique case (state_q)
            IDLE, ACC: begin
                if (i_clear) begin
                    // Abort the vector; a sample offered this cycle is dropped.
                    sum_x_d  = '0;
                    sum_x2_d = '0;
                    count_d  = '0;
                    state_d  = IDLE;
                end else if (accept) begin
                    if (state_q == IDLE) begin
                        sum_x_d  = {{6{i_x[15]}}, i_x};
                        sum_x2_d = {5'b0, x_sq};
                        count_d  = 7'd1;
                    end else begin
                        sum_x_d  = sum_x_q + {{6{i_x[15]}}, i_x};
                        sum_x2_d = sum_x2_q + {5'b0, x_sq};
                        count_d  = count_q + 7'd1;
                    end
                    state_d = ACC;
                    if (count_d == TARGET) begin
                        // Results captured on entry to DONE, held until next DONE.
                        state_d = DONE;
                        ex_d    = mean_x(sum_x_d);
                        ex2_d   = mean_x2(sum_x2_d);
                    end
                end
            end
            DONE: begin
                // i_clear is irrelevant here: the vector is already complete.
                sum_x_d  = '0;
                sum_x2_d = '0;
                count_d  = '0;
                state_d  = IDLE;
            end
            default: begin
                state_d  = IDLE;
                sum_x_d  = '0;
                sum_x2_d = '0;
                count_d  = '0;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q  <= IDLE;
            sum_x_q  <= '0;
            sum_x2_q <= '0;
            count_q  <= '0;
            ex_q     <= '0;
            ex2_q    <= '0;
        end else begin
            state_q  <= state_d;
            sum_x_q  <= sum_x_d;
            sum_x2_q <= sum_x2_d;
            count_q  <= count_d;
            ex_q     <= ex_d;
            ex2_q    <= ex2_d;
        end
    end

    // Outputs are direct views of registered state.
    always_comb begin
        o_ready = (state_q != DONE);
        o_valid = (state_q == DONE);
        o_Ex    = ex_q;
        o_Ex2   = ex2_q;
        o_count = count_q;
        o_state = state_q;
    end

endmodule
